// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Round-robin arbiter sharing one 128x8 memory port among four requesters
// (fetch, load/store, DMA, debug). One transaction at a time is placed on the
// memory's en/read/write/address/input_data/ready interface. A watchdog ends
// transactions whose mem_ready never arrives and flags them with err.
//
// Handshakes:
//   Requester side: a requester raises req[i] (level) together with wr[i],
//   its address and write data, and holds req until it sees done[i]. gnt[i]
//   is high from the grant cycle through the done cycle. Request fields are
//   latched at grant; later changes are ignored. done[i] is a one-cycle pulse.
//   rdata is valid in the done cycle of a read. err accompanies done when the
//   transaction timed out. The requester drops req in its done cycle. A req
//   still high at the next idle evaluation counts as a new request.
//   Memory side: mem_en with mem_read or mem_write stays constant for the
//   whole access; the access completes on the first posedge that samples
//   mem_ready high. mem_ready outside an access is ignored.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req, wr            per-requester request level and direction (1=write)
//   addr, wdata        packed per-requester address / write data
//   gnt, done, err     grant (one-hot), completion pulse, timeout flag
//   rdata              read data, valid with done on a read
//   mem_*              memory port (en/read/write/address/input/output/ready)
//   state_dbg          current FSM state, for checkers
module mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          wr,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_input_data,
  input  logic [DATA_W-1:0]         mem_output_data,
  input  logic                      mem_ready,
  output logic [1:0]                state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state;
  logic [1:0]        ptr;
  logic [1:0]        idx_l;
  logic              wr_l;
  logic [CNT_W-1:0]  cnt;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [1:0]        cand;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Scan ptr, ptr+1, ... from the far end so the closest asserted index
  // (lowest offset from ptr) is the last one written and therefore wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Field mux for the selected requester.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == 2'(k)) begin
        sel_wr    = wr[k];
        sel_addr  = addr[k*ADDR_W +: ADDR_W];
        sel_wdata = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // TIMEOUT == 0 disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  assign state_dbg = state;

  // mem_address and mem_input_data double as the latched request fields,
  // so they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      idx_l          <= '0;
      wr_l           <= 1'b0;
      cnt            <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      rdata          <= '0;
      mem_en         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx_l          <= pick_idx;
            wr_l           <= sel_wr;
            mem_address    <= sel_addr;
            mem_input_data <= sel_wr ? sel_wdata : '0;
            gnt            <= onehot(pick_idx);
            cnt            <= '0;
            mem_en         <= 1'b1;
            mem_read       <= ~sel_wr;
            mem_write      <= sel_wr;
            state          <= ACCESS;
          end
        end

        ACCESS: begin
          cnt <= cnt + 1'b1;
          // Ready takes precedence over a coincident timeout.
          if (mem_ready) begin
            if (!wr_l) begin
              rdata <= mem_output_data;
            end
            err       <= 1'b0;
            done      <= onehot(idx_l);
            mem_en    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            rdata     <= '0;
            done      <= onehot(idx_l);
            mem_en    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          ptr   <= idx_l + 2'd1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// --------------
// Bench for mem_arbiter. All stimulus, the memory model, the reference model
// and the checks run from one process, once per cycle at the falling edge:
// the reference model advances using the inputs the DUT sampled at the
// preceding rising edge, then DUT outputs are compared, then the memory and
// the requesters drive new input values for the next rising edge.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [3:0]  wr    = '0;
  logic [27:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        mem_en;
  logic        mem_read;
  logic        mem_write;
  logic [6:0]  mem_address;
  logic [7:0]  mem_input_data;
  logic [7:0]  mem_output_data = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mem_arbiter #(
    .N_REQ(4), .TIMEOUT(TIMEOUT), .ADDR_W(7), .DATA_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data), .mem_ready(mem_ready),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction phases) ----------------
  int         m_ph  = 0;   // 0 waiting, 1 memory access, 2 completion cycle
  int         m_ptr = 0;
  int         m_idx = 0;
  int         m_acc = 0;   // access cycles completed so far
  logic       m_err = 1'b0;
  logic [7:0] m_rdata = '0;
  logic       t_wr = 1'b0;
  logic [6:0] t_addr = '0;
  logic [7:0] t_wdata = '0;

  logic [7:0] mem [128];

  // requester records (values presented with req)
  bit   [3:0] r_active = '0;
  logic       r_wr    [4];
  logic [6:0] r_addr  [4];
  logic [7:0] r_wdata [4];

  // stimulus controls
  int auto_pct   = 0;
  bit scramble   = 1'b0;
  bit drop_early = 1'b0;
  bit never_rdy  = 1'b0;
  int lat_max    = 0;
  bit long_lat   = 1'b0;
  bit noise      = 1'b0;
  int mem_wait   = 0;
  int cur_lat    = 0;

  // grant order log
  bit         log_on = 1'b0;
  logic [3:0] prev_gnt = '0;
  logic [1:0] gnt_log[$];
  logic [1:0] exp_q[$];

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
    return 2'd0;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_ph  = 0;
      m_ptr = 0;
    end else begin
      case (m_ph)
        0: if (req != 4'b0000) begin
          m_idx   = rr_pick(req, m_ptr);
          m_ph    = 1;
          m_acc   = 0;
          t_wr    = r_wr[m_idx];
          t_addr  = r_addr[m_idx];
          t_wdata = r_wdata[m_idx];
        end
        1: begin
          m_acc++;
          if (mem_ready) begin
            m_ph  = 2;
            m_err = 1'b0;
            if (t_wr) mem[t_addr] = t_wdata;
            else      m_rdata     = mem[t_addr];
          end else if (m_acc == TIMEOUT) begin
            m_ph    = 2;
            m_err   = 1'b1;
            m_rdata = 8'h00;
          end
        end
        default: begin
          m_ptr = (m_idx + 1) % 4;
          m_ph  = 0;
        end
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << m_idx;
    check("gnt_count", 32'($countones(gnt)), (m_ph == 0) ? 0 : 1);
    check("done_at_most_one", 32'($countones(done) <= 1), 1);
    check("gnt", gnt, (m_ph == 0) ? 4'b0000 : exp_oh);
    check("done", done, (m_ph == 2) ? exp_oh : 4'b0000);
    check("mem_en", mem_en, m_ph == 1);
    check("mem_read", mem_read, (m_ph == 1) && !t_wr);
    check("mem_write", mem_write, (m_ph == 1) && t_wr);
    if (m_ph == 1) begin
      check("mem_address", mem_address, t_addr);
      check("mem_input_data", mem_input_data, t_wr ? t_wdata : 8'h00);
    end
    if (m_ph == 2) begin
      check("err", err, m_err);
      if (!t_wr || m_err) check("rdata", rdata, m_rdata);
    end else begin
      check("err_quiet", err, 0);
    end
  endtask

  task automatic log_grant();
    if (log_on && gnt != 4'b0000 && prev_gnt == 4'b0000) gnt_log.push_back(idx_of(gnt));
    prev_gnt = gnt;
  endtask

  // Memory: answers an access after cur_lat extra cycles (or never), and
  // toggles mem_ready randomly outside accesses when noise is on.
  task automatic memory_model();
    if (mem_en) begin
      if (!never_rdy && mem_wait >= cur_lat) begin
        mem_ready       = 1'b1;
        mem_output_data = mem[mem_address];
      end else begin
        mem_ready       = 1'b0;
        mem_output_data = 8'($urandom);
      end
      mem_wait++;
    end else begin
      mem_ready       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_output_data = 8'($urandom);
      mem_wait        = 0;
      cur_lat         = (long_lat && $urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, lat_max);
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
    r_active[i]    = 1'b1;
    r_wr[i]        = w;
    r_addr[i]      = a;
    r_wdata[i]     = d;
    req[i]         = 1'b1;
    wr[i]          = w;
    addr[i*7 +: 7] = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic drive_requesters();
    if (reset) begin
      r_active = '0;
      req      = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_active[i]) begin
          if (m_ph == 2 && m_idx == i) begin
            req[i]      = 1'b0;
            r_active[i] = 1'b0;
          end else if (m_ph == 1 && m_idx == i) begin
            if (scramble) begin
              wr[i]           = 1'($urandom);
              addr[i*7 +: 7]  = 7'($urandom);
              wdata[i*8 +: 8] = 8'($urandom);
            end
            if (drop_early && $urandom_range(0, 3) == 0) req[i] = 1'b0;
          end
        end else if (auto_pct != 0 && $urandom_range(1, 100) <= auto_pct) begin
          issue(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare_outputs();
    log_grant();
    memory_model();
    drive_requesters();
  endtask

  task automatic wait_done(input string tag, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      tick();
      if (done != 4'b0000) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    check({tag, "_seen"}, 32'(seen), 1);
  endtask

  task automatic drain(input string tag);
    auto_pct = 0;
    for (int k = 0; k < 400 && (r_active != 4'b0000 || m_ph != 0); k++) tick();
    check({tag, "_drained"}, 32'(r_active), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    int en_cnt;
    bit seen;

    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    mem[5] = 8'hA7;
    for (int i = 0; i < 4; i++) begin
      r_wr[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end

    repeat (3) tick();
    reset = 1'b0;
    check("reset_rdata", rdata, 8'h00);
    check("reset_mem_address", mem_address, 7'h00);
    check("reset_mem_input_data", mem_input_data, 8'h00);
    tick();

    // single read, zero-latency memory
    issue(0, 1'b0, 7'd5, 8'h55);
    wait_done("single_read", cyc);
    check("single_read_latency", cyc, 2);
    check("single_read_done", done, 4'b0001);
    check("single_read_rdata", rdata, 8'hA7);
    check("single_read_err", err, 0);
    tick();

    // write then read back from requester 2, bus fields scrambled after grant
    scramble = 1'b1;
    issue(2, 1'b1, 7'h7F, 8'h3C);
    wait_done("write", cyc);
    check("write_done", done, 4'b0100);
    tick();
    issue(2, 1'b0, 7'h7F, 8'h00);
    wait_done("readback", cyc);
    check("readback_rdata", rdata, 8'h3C);
    tick();

    // priority rotation: last grant was requester 2, so 0 goes before 2
    issue(0, 1'b0, 7'd1, 8'h00);
    issue(2, 1'b0, 7'd2, 8'h00);
    wait_done("rot_first", cyc);
    check("rot_first_done", done, 4'b0001);
    wait_done("rot_second", cyc);
    check("rot_second_done", done, 4'b0100);
    tick();

    // round robin from a fresh reset with every req held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gnt_log.delete();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    lat_max  = 2;
    noise    = 1'b1;
    log_on   = 1'b1;
    auto_pct = 100;
    for (int k = 0; k < 200 && gnt_log.size() < 6; k++) tick();
    log_on = 1'b0;
    drain("rr");
    check("rr_grant_count", gnt_log.size() >= 6, 1);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) check($sformatf("rr_order_%0d", k), gnt_log[k], exp_q[k]);

    // timeout: memory never answers
    noise   = 1'b0;
    lat_max = 0;
    tick();
    issue(1, 1'b0, 7'd5, 8'h00);
    wait_done("pre_to", cyc);
    check("pre_to_rdata", rdata, 8'hA7);
    tick();
    never_rdy = 1'b1;
    issue(3, 1'b0, 7'd9, 8'h00);
    en_cnt = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (mem_en) en_cnt++;
      if (done != 4'b0000) seen = 1'b1;
    end
    check("to_seen", 32'(seen), 1);
    check("to_en_cycles", en_cnt, TIMEOUT);
    check("to_done", done, 4'b1000);
    check("to_err", err, 1);
    check("to_rdata", rdata, 8'h00);
    never_rdy = 1'b0;
    tick();
    issue(1, 1'b0, 7'd5, 8'h00);
    wait_done("after_to", cyc);
    check("after_to_err", err, 0);
    check("after_to_rdata", rdata, 8'hA7);
    check("after_to_done", done, 4'b0010);
    tick();

    // reset during the third access cycle
    never_rdy = 1'b1;
    issue(3, 1'b1, 7'd20, 8'h99);
    repeat (3) tick();
    check("pre_reset_mem_en", mem_en, 1);
    reset = 1'b1;
    tick();
    check("mid_reset_mem_en", mem_en, 0);
    check("mid_reset_done", done, 4'b0000);
    reset     = 1'b0;
    never_rdy = 1'b0;
    issue(1, 1'b0, 7'd5, 8'h00);
    issue(3, 1'b0, 7'd6, 8'h00);
    wait_done("post_reset_first", cyc);
    check("post_reset_first_done", done, 4'b0010);
    wait_done("post_reset_second", cyc);
    check("post_reset_second_done", done, 4'b1000);
    tick();

    // randomized traffic: latency, long stalls, ready noise, early req drop
    lat_max    = 3;
    long_lat   = 1'b1;
    noise      = 1'b1;
    scramble   = 1'b1;
    drop_early = 1'b1;
    auto_pct   = 25;
    repeat (3000) tick();
    long_lat = 1'b0;
    drain("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
